// File: rtl/spi_frame_rx.sv
// spi_frame_rx
// SPI mode-0 slave receiver. Brings the asynchronous SPI pins into the clk
// domain and assembles MSB-first WIDTH-bit words. Each completed word is
// presented on data_out together with a one-cycle valid strobe. Chip select
// marks the word boundaries, so a partial word is dropped when cs_n rises.
//
// Ports
//   clk          system clock
//   rstn         synchronous reset, active-low
//   sclk         SPI clock from the MCU (asynchronous)
//   cs_n         SPI chip select, active-low (asynchronous)
//   mosi         SPI data (asynchronous)
//   data_out     last completed word; held until the next word completes
//   valid        one-clk pulse when data_out is updated
//   busy         high while the synchronized cs_n is low
//   frame_error  one-clk pulse at frame end when the frame was malformed
//
// Optional feature
//   SPI_FRAME_CHECK_EN  builds the word counter and the frame-length check.
//                       When it is not defined, frame_error is tied to 0.
module spi_frame_rx #(
  parameter int WIDTH       = 8,
  parameter int FRAME_WORDS = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Stage 0: two-flop synchronizers, plus a third flop on sclk and cs_n for
  // edge detection.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  // prime_q[2] marks cs_q[2] as holding a real pin sample. The chip select
  // pipeline resets to "deasserted". Without this mark, a pin that is still
  // low when reset releases would look like a new falling edge and would
  // resume an aborted frame.
  logic [2:0] prime_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_q  <= 3'b000;
      cs_q    <= 3'b111;
      mosi_q  <= 2'b00;
      prime_q <= 3'b000;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_q    <= {cs_q[1:0], cs_n};
      mosi_q  <= {mosi_q[0], mosi};
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  // Stage 1: registered edge detection. mosi travels alongside sclk so that
  // the sampled bit stays aligned with its edge.
  logic sclk_rise_q;
  logic cs_fall_q;
  logic cs_rise_q;
  logic mosi_e_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
      cs_fall_q   <= ~cs_q[1] & cs_q[2] & prime_q[2];
      cs_rise_q   <= cs_q[1] & ~cs_q[2];
    end
  end

  always_ff @(posedge clk) begin
    mosi_e_q <= mosi_q[1];
  end

  // Stage 2: word assembly, counters and registered outputs.
  state_t            state_q;
  logic [BW-1:0]     bitcnt_q;
  logic [BW-1:0]     bit_d;
  logic [WIDTH-2:0]  shreg_q;
  logic [WIDTH-1:0]  word_w;
  logic              word_done;
  logic [WIDTH-1:0]  data_out_q;
  logic              valid_q;
  logic              busy_q;

  assign word_w    = {shreg_q, mosi_e_q};
  assign word_done = sclk_rise_q && (bitcnt_q == BIT_LAST);

  always_comb begin
    bit_d = bitcnt_q;
    if (sclk_rise_q) begin
      bit_d = word_done ? '0 : bitcnt_q + 1'b1;
    end
  end

`ifdef SPI_FRAME_CHECK_EN
  localparam int WCW = $clog2(FRAME_WORDS + 2);
  localparam logic [WCW-1:0] WORD_MAX = WCW'(FRAME_WORDS + 1);
  localparam logic [WCW-1:0] WORD_EXP = WCW'(FRAME_WORDS);

  logic [WCW-1:0] wordcnt_q;
  logic [WCW-1:0] word_d;
  logic           frame_bad;
  logic           frame_error_q;

  // The counter saturates one step beyond the expected length, so an overlong
  // frame can never wrap back to a count that looks correct.
  always_comb begin
    word_d = wordcnt_q;
    if (word_done && (wordcnt_q != WORD_MAX)) begin
      word_d = wordcnt_q + 1'b1;
    end
  end

  // The check uses the next-state counts, so a word that completes in the
  // same cycle as the cs_n rise is counted before the frame is judged.
  assign frame_bad   = (word_d != WORD_EXP) || (bit_d != '0);
  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
      wordcnt_q     <= '0;
      frame_error_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      busy_q  <= ~cs_q[1];
`ifdef SPI_FRAME_CHECK_EN
      frame_error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          bitcnt_q <= '0;
`ifdef SPI_FRAME_CHECK_EN
          wordcnt_q <= '0;
`endif
          if (cs_fall_q) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bitcnt_q <= bit_d;
`ifdef SPI_FRAME_CHECK_EN
          wordcnt_q <= word_d;
`endif
          if (word_done) begin
            data_out_q <= word_w;
            valid_q    <= 1'b1;
          end
          // End of frame: the counters restart, and any partial word stays
          // in shreg_q. It is never emitted, because a new frame shifts in a
          // full word before the next strobe.
          if (cs_rise_q) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
`ifdef SPI_FRAME_CHECK_EN
            wordcnt_q     <= '0;
            frame_error_q <= frame_bad;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == SHIFT) && sclk_rise_q) begin
      shreg_q <= word_w[WIDTH-2:0];
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;
  localparam int W  = 8;
  localparam int FW = 64;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         frame_error;

  spi_frame_rx #(.WIDTH(W), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .data_out(data_out), .valid(valid), .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observation logs filled once per clock, after the active edge.
  logic [W-1:0] got_q[$];
  int           lat_q[$];
  int           ferr_cnt  = 0;
  int           busy_cnt  = 0;
  int           cslow_cnt = 0;
  int           cyc       = 0;
  int           last_rise = 0;
  logic [W-1:0] exp_last  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (cs_n == 1'b0) cslow_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      got_q.push_back(data_out);
      lat_q.push_back(cyc - last_rise);
    end
    if (frame_error) ferr_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic clear_logs();
    got_q.delete();
    lat_q.delete();
    ferr_cnt  = 0;
    busy_cnt  = 0;
    cslow_cnt = 0;
  endtask

  // One SPI bit: mosi is set up during the 4-clk low phase and held through
  // the 4-clk high phase. raise_cs lifts chip select on this rising edge.
  task automatic send_bit(input logic b, input bit raise_cs);
    mosi = b;
    repeat (4) tick();
    sclk = 1'b1;
    last_rise = cyc;
    if (raise_cs) cs_n = 1'b1;
    repeat (4) tick();
    sclk = 1'b0;
  endtask

  // Sends the given whole bytes and then extra_bits leading bits of a junk
  // byte. The reference: every whole byte appears once, in order. Only when
  // the frame check is built is a frame flagged, and only if it is not
  // exactly FW whole bytes.
  task automatic run_frame(input string tag, input logic [W-1:0] bytes[$],
                           input int extra_bits, input bit coincide);
    logic [W-1:0] junk;
    int           exp_ferr;
    bit           last;
    junk = W'($urandom);
    clear_logs();
    cs_n = 1'b0;
    tick();
    tick();
    check({tag, ".busy_pre"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".busy_lat"}, 32'(busy), 32'd1);
    tick();
    foreach (bytes[i]) begin
      for (int k = W - 1; k >= 0; k--) begin
        last = coincide && (i == bytes.size() - 1) && (k == 0) && (extra_bits == 0);
        send_bit(bytes[i][k], last);
      end
    end
    for (int k = 0; k < extra_bits; k++) send_bit(junk[W-1-k], 1'b0);
    if (cs_n == 1'b0) begin
      repeat (4) tick();
      cs_n = 1'b1;
    end
    repeat (8) tick();

`ifdef SPI_FRAME_CHECK_EN
    exp_ferr = ((extra_bits != 0) || (bytes.size() != FW)) ? 1 : 0;
`else
    exp_ferr = 0;
`endif
    if (bytes.size() > 0) exp_last = bytes[bytes.size() - 1];

    check({tag, ".count"}, 32'(got_q.size()), 32'(bytes.size()));
    for (int i = 0; i < bytes.size() && i < got_q.size(); i++) begin
      check($sformatf("%s.word%0d", tag, i), 32'(got_q[i]), 32'(bytes[i]));
      check($sformatf("%s.lat%0d", tag, i), 32'(lat_q[i]), 32'd4);
    end
    check({tag, ".frame_error"}, 32'(ferr_cnt), 32'(exp_ferr));
    check({tag, ".busy_len"}, 32'(busy_cnt), 32'(cslow_cnt));
    check({tag, ".data_hold"}, 32'(data_out), 32'(exp_last));
  endtask

  initial begin
    logic [W-1:0] bq[$];
    int           nb;
    int           xb;

    // Power-on reset.
    rstn = 1'b0;
    tick();
    tick();
    check("rst.data_out", 32'(data_out), 32'd0);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.frame_error", 32'(frame_error), 32'd0);
    rstn = 1'b1;
    repeat (4) tick();

    // Two-byte frame.
    bq = '{8'hA5, 8'h3C};
    run_frame("two", bq, 0, 1'b0);

    // A good byte, then a word truncated after 5 bits.
    bq = '{8'h81};
    run_frame("trunc", bq, 5, 1'b0);

    // A full frame with byte i carrying the value i.
    bq.delete();
    for (int i = 0; i < FW; i++) bq.push_back(W'(i));
    run_frame("full64", bq, 0, 1'b0);

    // An overlong frame.
    bq.delete();
    for (int i = 0; i < FW + 1; i++) bq.push_back(W'($urandom));
    run_frame("over65", bq, 0, 1'b0);

    // sclk activity with chip select high is ignored.
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      sclk = ~sclk;
      repeat (4) tick();
    end
    sclk = 1'b0;
    repeat (4) tick();
    check("idle_sclk.count", 32'(got_q.size()), 32'd0);
    check("idle_sclk.busy", 32'(busy_cnt), 32'd0);
    check("idle_sclk.data_out", 32'(data_out), 32'(exp_last));

    // Reset in the middle of a byte.
    cs_n = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    rstn = 1'b0;
    tick();
    check("midrst.data_out", 32'(data_out), 32'd0);
    check("midrst.valid", 32'(valid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.frame_error", 32'(frame_error), 32'd0);
    rstn = 1'b1;
    exp_last = '0;
    // Chip select is still low from before the reset. The aborted frame must
    // not resume.
    clear_logs();
    for (int k = 0; k < W; k++) send_bit(1'b1, 1'b0);
    repeat (4) tick();
    cs_n = 1'b1;
    repeat (8) tick();
    check("midrst.no_resume", 32'(got_q.size()), 32'd0);
    check("midrst.no_ferr", 32'(ferr_cnt), 32'd0);
    check("midrst.data_out_hold", 32'(data_out), 32'd0);
    bq = '{8'hFF};
    run_frame("post_rst", bq, 0, 1'b0);

    // The last sclk rise lands on the same clk as the cs_n rise.
    bq = '{8'h7E};
    run_frame("coincide", bq, 0, 1'b1);

    // Randomized frames: random length, random payload, random tail.
    for (int f = 0; f < 6; f++) begin
      nb = int'($urandom_range(0, 5));
      xb = int'($urandom_range(0, W - 1));
      bq.delete();
      for (int i = 0; i < nb; i++) bq.push_back(W'($urandom));
      run_frame($sformatf("rnd%0d", f), bq, xb, (xb == 0 && nb > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

SPI mode-0 slave receiver that deserializes MCU command bytes into WIDTH-bit words for the FPGA control unit. It synchronizes the asynchronous SPI pins into the system clock domain, assembles MSB-first words, and emits a one-cycle `valid` strobe per word that drives the control unit's `enable`/`sig_in` pair. Chip-select framing resynchronizes word boundaries, and a frame-length check flags malformed configuration transfers.

## Interface
- `WIDTH`, 8, bits per SPI word; must match the control unit's `WIDTH`.
- `FRAME_WORDS`, 64, expected words per chip-select frame (= `$bits(synth_t)/WIDTH`); must be ≥1.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `sclk`  in  1  SPI clock from MCU, asynchronous.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  SPI data, asynchronous.
- `data_out`  out  WIDTH  last completed word; held until the next word completes.
- `valid`  out  1  one-`clk` pulse when `data_out` is updated.
- `busy`  out  1  high while synchronized `cs_n` is low.
- `frame_error`  out  1  one-`clk` pulse at frame end if the frame was malformed.

## Operation
- Input sync: `sclk`, `cs_n`, `mosi` each pass through 2 flops; reset values are `sclk`=0, `cs_n`=1, `mosi`=0. A third `sclk` flop provides rising/falling edge detection.
- States: IDLE, SHIFT.
  - IDLE: the bit counter and word counter are 0. A synchronized `cs_n` falling edge moves the FSM to SHIFT.
  - SHIFT: on each synchronized `sclk` rising edge, `shreg <= {shreg[WIDTH-2:0], mosi_s}` and `bitcnt++`.
    - When `bitcnt` reaches WIDTH-1 and a rising edge occurs: `data_out <= {shreg[WIDTH-2:0], mosi_s}`, `valid` pulses, `bitcnt` wraps to 0, and `wordcnt` increments (saturating at `FRAME_WORDS`+1).
  - SHIFT, synchronized `cs_n` rising edge: go to IDLE. Any partial word is discarded; `data_out` is not updated and no `valid` is issued.
- `sclk` edges while `cs_n` is high are ignored.
- If a `cs_n` rise and the final `sclk` rise are detected in the same `clk`, the word completes first (`valid` is issued), then the FSM goes to IDLE.
- `data_out` is never cleared except by reset.
- Arithmetic widths: `bitcnt` is `$clog2(WIDTH)` bits; `wordcnt` is `$clog2(FRAME_WORDS+2)` bits. No wrap is permitted.
- Reset mid-frame: all state returns to IDLE on the next `clk`, regardless of pin activity. A frame already in progress is not resumed; the next `cs_n` falling edge starts a new frame.

## Timing
- Reset values: `data_out`=0, `valid`=0, `busy`=0, `frame_error`=0, FSM=IDLE, all counters=0.
- Latency: `valid` rises on the 4th `clk` edge after the `sclk` rising edge of the last bit (2 sync + 1 edge detect + 1 output register). `data_out` is valid in the same cycle as `valid`.
- `busy` follows `cs_n` with 3 `clk` cycles of latency.
- Constraints: `sclk` high and low phases must each be ≥3 `clk` periods. `mosi` must be stable from 1 `clk` before to 3 `clk` after each `sclk` rising edge.
- Minimum `cs_n` high time between frames: 3 `clk`.
- Downstream needs no back-pressure. The consumer must accept `valid` in any cycle; words arrive at least 6·WIDTH `clk` apart.

## Configuration
- `SPI_FRAME_CHECK_EN` defined: the word counter is built.
  - On `cs_n` rise, `frame_error` pulses for 1 `clk` (same cycle as the IDLE transition) if `wordcnt != FRAME_WORDS` or `bitcnt != 0`.
- Not defined: `wordcnt` logic is omitted and `frame_error` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then one frame of bytes 0xA5, 0x3C (`FRAME_WORDS`=2) -> two `valid` pulses with `data_out` 0xA5 then 0x3C; `frame_error`=0; `busy` high for the frame duration + 3 `clk`.
- `cs_n` rises after 5 bits of a second byte, following a good byte 0x81 -> no second `valid`; `data_out` stays 0x81; with the macro defined, `frame_error` pulses once.
- Full 64-byte frame with payload `i` for byte `i` -> 64 `valid` pulses in order 0x00..0x3F; `frame_error`=0. A 65-byte frame -> `frame_error`=1 at `cs_n` rise.
- `sclk` toggled 16 times with `cs_n` high -> no `valid`, `busy`=0, `data_out` unchanged.
- `rstn` asserted for 1 `clk` after 3 bits of a byte, then a clean frame containing 0xFF -> `valid` with 0xFF. No stale bits appear; all outputs were 0 during reset.
- Last `sclk` rise coincident with `cs_n` rise, byte 0x7E -> `valid` with 0x7E, then IDLE.
